// File: rtl/posit_encode_prod_sum_es3.sv
// Packs the es3 product-adder raw sum {sgn, scale, fraction, inf, zero} into an NBITS posit with RNE.
// Input capture plus three processing stages (start at edge N -> done after N+3); 1 word/cycle, never stalls.
package posit_es3_pkg;
  localparam int AMBITS = 56;
endpackage

module posit_encode_prod_sum_es3 #(
  parameter int NBITS   = 32,
  parameter int ES      = 3,
  parameter int SCALE_W = 10,
  parameter int FRAC_W  = posit_es3_pkg::AMBITS
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [SCALE_W+FRAC_W+2:0]     in_sum,
  input  logic                          truncated,
  output logic [NBITS-1:0]              result,
  output logic                          done
);

  localparam int K_W      = SCALE_W - ES;
  localparam int SH_W     = K_W - 1;
  localparam int PAD      = 2 ** SH_W;
  localparam int T_W      = 2 + ES + FRAC_W;
  localparam int X_W      = T_W + PAD;
  localparam int P_W      = NBITS - 1;
  localparam int MAXSCALE = (NBITS - 2) * (2 ** ES);

  // input capture
  logic                        s0_vld_q;
  logic [SCALE_W+FRAC_W+2:0]   s0_sum_q;
  logic                        s0_trunc_q;

  // decode
  logic                        s1_vld_q;
  logic                        s1_sgn_q;
  logic signed [K_W-1:0]       s1_k_q;
  logic [ES-1:0]               s1_e_q;
  logic [FRAC_W-1:0]           s1_frac_q;
  logic                        s1_inf_q;
  logic                        s1_zero_q;
  logic                        s1_sat_hi_q;
  logic                        s1_sat_lo_q;
  logic                        s1_trunc_q;

  // assemble
  logic                        s2_vld_q;
  logic                        s2_sgn_q;
  logic [P_W-1:0]              s2_payload_q;
  logic                        s2_guard_q;
  logic                        s2_sticky_q;
  logic                        s2_inf_q;
  logic                        s2_zero_q;
  logic                        s2_sat_hi_q;
  logic                        s2_sat_lo_q;

  logic [NBITS-1:0]            result_q;
  logic                        done_q;

  logic                        s0_sgn;
  logic signed [SCALE_W-1:0]   s0_scale;
  logic [FRAC_W-1:0]           s0_frac;
  logic                        s0_inf;
  logic                        s0_zero;
  logic signed [K_W-1:0]       s1_k_d;
  logic [ES-1:0]               s1_e_d;
  logic                        s1_sat_hi_d;
  logic                        s1_sat_lo_d;

  logic [SH_W-1:0]             shamt;
  logic signed [X_W-1:0]       ext;
  logic signed [X_W-1:0]       shifted;
  logic [P_W-1:0]              s2_payload_d;
  logic                        s2_guard_d;
  logic                        s2_sticky_d;

  logic                        rnd_up;
  logic [NBITS-1:0]            rnd_sum;
  logic [P_W-1:0]              payload_fin;
  logic [NBITS-1:0]            magnitude;
  logic [NBITS-1:0]            result_d;

  assign {s0_sgn, s0_scale, s0_frac, s0_inf, s0_zero} = s0_sum_q;

  // Keeping the scale bits above ES is exactly scale >>> ES.
  assign s1_k_d      = s0_scale[SCALE_W-1:ES];
  assign s1_e_d      = s0_scale[ES-1:0];
  assign s1_sat_hi_d = int'(s0_scale) > MAXSCALE;
  assign s1_sat_lo_d = int'(s0_scale) < -MAXSCALE;

  // Seed "10" (k>=0) or "01" (k<0); the arithmetic shift then replicates the
  // leading regime bit to reach k+1 ones or -k zeros.
  assign shamt   = s1_k_q[K_W-1] ? ~s1_k_q[SH_W-1:0] : s1_k_q[SH_W-1:0];
  assign ext     = {~s1_k_q[K_W-1], s1_k_q[K_W-1], s1_e_q, s1_frac_q, {PAD{1'b0}}};
  assign shifted = ext >>> shamt;

  assign s2_payload_d = shifted[X_W-1 -: P_W];
  assign s2_guard_d   = shifted[X_W-1-P_W];
  assign s2_sticky_d  = (|shifted[X_W-2-P_W:0]) | s1_trunc_q;

  always_comb begin
    rnd_up      = s2_guard_q & (s2_payload_q[0] | s2_sticky_q);
    rnd_sum     = {1'b0, s2_payload_q} + {{(NBITS-1){1'b0}}, rnd_up};
    payload_fin = rnd_sum[NBITS-1] ? {P_W{1'b1}} : rnd_sum[P_W-1:0];
    if (payload_fin == '0) begin
      payload_fin = {{(P_W-1){1'b0}}, 1'b1};
    end
    if (s2_sat_hi_q) begin
      payload_fin = {P_W{1'b1}};
    end else if (s2_sat_lo_q) begin
      payload_fin = {{(P_W-1){1'b0}}, 1'b1};
    end
    magnitude = {1'b0, payload_fin};
    result_d  = s2_sgn_q ? (~magnitude + 1'b1) : magnitude;
    if (s2_inf_q) begin
      result_d = {1'b1, {(NBITS-1){1'b0}}};
    end else if (s2_zero_q) begin
      result_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_vld_q     <= 1'b0;
      s0_sum_q     <= '0;
      s0_trunc_q   <= 1'b0;
      s1_vld_q     <= 1'b0;
      s1_sgn_q     <= 1'b0;
      s1_k_q       <= '0;
      s1_e_q       <= '0;
      s1_frac_q    <= '0;
      s1_inf_q     <= 1'b0;
      s1_zero_q    <= 1'b0;
      s1_sat_hi_q  <= 1'b0;
      s1_sat_lo_q  <= 1'b0;
      s1_trunc_q   <= 1'b0;
      s2_vld_q     <= 1'b0;
      s2_sgn_q     <= 1'b0;
      s2_payload_q <= '0;
      s2_guard_q   <= 1'b0;
      s2_sticky_q  <= 1'b0;
      s2_inf_q     <= 1'b0;
      s2_zero_q    <= 1'b0;
      s2_sat_hi_q  <= 1'b0;
      s2_sat_lo_q  <= 1'b0;
      result_q     <= '0;
      done_q       <= 1'b0;
    end else begin
      s0_vld_q     <= start;
      s0_sum_q     <= in_sum;
      s0_trunc_q   <= truncated;

      s1_vld_q     <= s0_vld_q;
      s1_sgn_q     <= s0_sgn;
      s1_k_q       <= s1_k_d;
      s1_e_q       <= s1_e_d;
      s1_frac_q    <= s0_frac;
      s1_inf_q     <= s0_inf;
      s1_zero_q    <= s0_zero;
      s1_sat_hi_q  <= s1_sat_hi_d;
      s1_sat_lo_q  <= s1_sat_lo_d;
      s1_trunc_q   <= s0_trunc_q;

      s2_vld_q     <= s1_vld_q;
      s2_sgn_q     <= s1_sgn_q;
      s2_payload_q <= s2_payload_d;
      s2_guard_q   <= s2_guard_d;
      s2_sticky_q  <= s2_sticky_d;
      s2_inf_q     <= s1_inf_q;
      s2_zero_q    <= s1_zero_q;
      s2_sat_hi_q  <= s1_sat_hi_q;
      s2_sat_lo_q  <= s1_sat_lo_q;

      done_q       <= s2_vld_q;
      if (s2_vld_q) begin
        result_q <= result_d;
      end
    end
  end

  assign result = result_q;
  assign done   = done_q;

endmodule

// File: tb/tb_posit_encode_prod_sum_es3.sv
// Directed bench for posit_encode_prod_sum_es3 with a bit-string reference model and per-cycle compare.
module tb_posit_encode_prod_sum_es3;

  localparam int FW   = 56;
  localparam int IN_W = 1 + 10 + FW + 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic            truncated;
  logic [IN_W-1:0] in_sum;
  logic [31:0]     result;
  logic            done;

  posit_encode_prod_sum_es3 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_sum    (in_sum),
    .truncated (truncated),
    .result    (result),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] val;
    int          due;
  } exp_t;

  exp_t        exp_q[$];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] last_res = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, req);
    end
  endtask

  // Reference: spell out regime/exponent/fraction as a bit list, then cut and round.
  function automatic logic [31:0] model(input bit sg, input int sc, input logic [FW-1:0] fr,
                                         input bit inf_b, input bit zero_b, input bit tr);
    bit          bits[$];
    int          k;
    int          e;
    logic [30:0] p;
    bit          g;
    bit          st;
    logic [31:0] r;
    if (inf_b) return 32'h8000_0000;
    if (zero_b) return 32'h0;
    if (sc > 240) begin
      p = 31'h7FFF_FFFF;
    end else if (sc < -240) begin
      p = 31'h1;
    end else begin
      if (sc >= 0) k = sc / 8;
      else k = -((-sc + 7) / 8);
      e = sc - 8 * k;
      if (k >= 0) begin
        for (int i = 0; i <= k; i++) bits.push_back(1'b1);
        bits.push_back(1'b0);
      end else begin
        for (int i = 0; i < -k; i++) bits.push_back(1'b0);
        bits.push_back(1'b1);
      end
      for (int i = 2; i >= 0; i--) bits.push_back(((e >> i) & 1) != 0);
      for (int i = FW - 1; i >= 0; i--) bits.push_back(fr[i]);
      p = '0;
      for (int i = 0; i < 31; i++) p = {p[29:0], bits[i]};
      g  = bits[31];
      st = tr;
      for (int i = 32; i < bits.size(); i++) st = st | bits[i];
      if (g && (p[0] || st) && (p != 31'h7FFF_FFFF)) p = p + 31'd1;
      if (p == 31'h0) p = 31'h1;
    end
    r = {1'b0, p};
    if (sg) r = -r;
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_done", {31'h0, done}, 32'h0);
      chk("reset_result", result, 32'h0);
      last_res = '0;
    end else if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      chk("done_high", {31'h0, done}, 32'h1);
      chk("result", result, exp_q[0].val);
      last_res = exp_q[0].val;
      void'(exp_q.pop_front());
    end else begin
      chk("done_low", {31'h0, done}, 32'h0);
      chk("result_hold", result, last_res);
    end
  end

  task automatic send(input bit sg, input int sc, input logic [FW-1:0] fr, input bit inf_b,
                      input bit zero_b, input bit tr, input bit pin, input logic [31:0] lit,
                      input string nm);
    logic [9:0]  sc10;
    logic [31:0] m;
    exp_t        ex;
    sc10 = sc[9:0];
    m = model(sg, sc, fr, inf_b, zero_b, tr);
    if (pin) chk({"model_", nm}, m, lit);
    start     = 1'b1;
    in_sum    = {sg, sc10, fr, inf_b, zero_b};
    truncated = tr;
    ex.val = m;
    ex.due = cyc + 4;
    exp_q.push_back(ex);
    @(posedge clk);
    #1;
    start     = 1'b0;
    truncated = 1'b0;
  endtask

  task automatic idle(input int n);
    start = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [FW-1:0] f0;
    logic [FW-1:0] fg;
    logic [FW-1:0] fr;
    logic [63:0]   r64;
    f0 = '0;
    fg = '0;
    fg[FW-27] = 1'b1;

    rst_n     = 1'b0;
    start     = 1'b1;
    truncated = 1'b1;
    in_sum    = {1'b0, 10'd8, {FW{1'b1}}, 2'b00};
    repeat (5) @(posedge clk);
    #1;
    start     = 1'b0;
    truncated = 1'b0;
    rst_n     = 1'b1;
    idle(4);

    send(0, 0,  f0, 0, 0, 0, 1, 32'h4000_0000, "one");
    send(0, -1, f0, 0, 0, 0, 1, 32'h3C00_0000, "scale_m1");
    send(1, 0,  f0, 0, 0, 0, 1, 32'hC000_0000, "neg_one");
    idle(2);

    send(0, 0,    fg, 0, 0, 0, 1, 32'h4000_0000, "tie_even");
    send(0, 0,    fg, 0, 0, 1, 1, 32'h4000_0001, "tie_sticky");
    send(0, 300,  f0, 0, 0, 0, 1, 32'h7FFF_FFFF, "sat_hi");
    send(0, -300, f0, 0, 0, 0, 1, 32'h0000_0001, "sat_lo");
    send(1, -300, f0, 0, 0, 0, 1, 32'hFFFF_FFFF, "sat_lo_neg");
    send(0, 5,    f0, 1, 1, 0, 1, 32'h8000_0000, "nar");
    send(1, 7,    fg, 0, 1, 1, 1, 32'h0000_0000, "zero");
    send(0, 240,  f0, 0, 0, 0, 1, 32'h7FFF_FFFF, "maxscale");
    send(0, -240, f0, 0, 0, 0, 1, 32'h0000_0001, "minscale");
    send(0, 8,    f0, 0, 0, 0, 1, 32'h6000_0000, "k_one");
    send(0, 1,    f0, 0, 0, 0, 1, 32'h4400_0000, "e_one");
    send(1, -1,   f0, 0, 0, 0, 1, 32'hC400_0000, "neg_scale_m1");
    send(0, 239,  f0, 0, 0, 0, 1, 32'h7FFF_FFFF, "round_to_max");
    idle(3);

    for (int s = -250; s <= 250; s += 11) begin
      r64 = {$urandom(), $urandom()};
      fr  = r64[FW-1:0];
      send(bit'($urandom_range(0, 1)), s, fr, 0, 0, bit'($urandom_range(0, 1)), 0, 32'h0, "sweep");
    end
    idle(5);

    send(0, 0,  f0, 0, 0, 0, 1, 32'h4000_0000, "flight_a");
    send(0, -1, f0, 0, 0, 0, 1, 32'h3C00_0000, "flight_b");
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle(4);
    send(1, 8, f0, 0, 0, 0, 1, 32'hA000_0000, "after_reset");
    idle(8);

    chk("drain", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/posit_encode_prod_sum_es3.md
Name: posit_encode_prod_sum_es3

Overview:
Pipelined encoder that consumes the serialized raw-sum word produced by the es3 product adder, i.e. {sgn, scale, fraction, inf, zero} plus its truncated flag. It packs that word into a standard NBITS posit (ES=3) with round-to-nearest-even. It sits directly downstream of the product accumulator and produces the posit written back to memory or the host. It accepts one input per cycle, with a fixed latency and a start/done valid pipeline.

Parameters:
NBITS, 32, output posit width
ES, 3, exponent field width (fixed for the es3 family; no other value is supported)
SCALE_W, 10, signed scale field width of the input word
FRAC_W, AMBITS (package constant), input fraction width; hidden bit excluded; MSB-aligned

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous, active-low reset
start  in  1  input word valid this cycle
in_sum  in  1+SCALE_W+FRAC_W+2  packed {sgn, scale (signed), fraction, inf, zero}, MSB first
truncated  in  1  nonzero bits were discarded upstream; used as an extra sticky bit
result  out  NBITS  encoded posit
done  out  1  result valid this cycle

Behaviour:
- Reset (async, rst_n=0): done=0, result=0, all stage valid bits=0, all in-flight words discarded. Release of rst_n takes effect at the next clk edge. start is ignored while rst_n=0.
- Pipeline: 3 register stages; throughput 1 word/cycle; no stall and no backpressure.
- Latency: if start=1 is sampled at edge N, done=1 and result is valid after edge N+3. done is high for exactly one cycle per accepted word.
- When done=0, result holds its last value.
- Stage 1 (register inputs, decode):
  - k = scale >>> ES (arithmetic shift); e = scale[ES-1:0].
  - maxscale = (NBITS-2)*2^ES = 240 at the defaults.
  - Flag sat_hi if scale > maxscale; flag sat_lo if scale < -maxscale.
- Stage 2 (assemble):
  - Regime = k+1 ones then a zero when k>=0; -k zeros then a one when k<0.
  - Concatenate regime, e (ES bits) and fraction.
  - Place the result left-aligned into an NBITS-1 payload plus guard bit.
  - sticky = OR(all bits below guard) | truncated.
  - The regime may consume the entire payload; the terminating bit and exponent bits may fall into guard/sticky.
- Stage 3 (round and sign):
  - Round up when guard & (payload LSB | sticky).
  - A carry out of the payload clamps the payload to all ones (maxpos); the result never wraps to NaR.
  - A nonzero input never rounds to zero: if payload==0, force payload=1 (minpos).
  - sat_hi gives payload all ones; sat_lo gives payload = 1.
  - Output = {0, payload}; if sgn=1 the output is the two's complement of {0, payload}.
- Specials, priority inf > zero > saturation > normal:
  - inf=1: result = 1 followed by NBITS-1 zeros (NaR), regardless of other fields.
  - zero=1 and inf=0: result = 0, regardless of sgn and fraction.
- Consecutive inputs on back-to-back cycles are fully independent; no state carries between words.
- Reset asserted mid-flight: every pending done is lost; no partial results appear after release.

Test Plan:
- Reset: hold rst_n=0 with start=1 for 5 cycles -> done=0 and result=0 throughout; release, start=0 -> done stays 0.
- Normal, back-to-back: in consecutive cycles send scale=0 frac=0 sgn=0; scale=-1 frac=0; scale=0 sgn=1 -> done high 3 cycles later for 3 consecutive cycles, result = 0x40000000, 0x3C000000, 0xC0000000.
- Rounding tie vs sticky: scale=0 with only fraction bit index FRAC_W-27 set (guard); truncated=0 -> 0x40000000 (tie to even); same input with truncated=1 -> 0x40000001.
- Saturation: scale=300 sgn=0 -> 0x7FFFFFFF; scale=-300 sgn=0 -> 0x00000001; scale=-300 sgn=1 -> 0xFFFFFFFF.
- Specials: inf=1 zero=1 scale=5 -> 0x80000000; zero=1 sgn=1 frac nonzero -> 0x00000000.
- Reset mid-flight: start pulses at edges N and N+1, rst_n low between N+1 and N+2 -> no done ever asserted for either word; a new word after release arrives with latency 3.
